load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte-addressed load/store front end for a word-wide RAM
//
// Purpose:
//   Accepts one load or store per req_valid/req_ready handshake and drives a
//   word-wide RAM that has no byte enables. Sub-word loads are lane-extracted
//   and sign/zero extended. SB/SH are done as read-modify-write.
//   Optional build macro: LSU_RANGE_CHECK_EN. When defined, any nonzero address
//   bit above the RAM window is an error. When undefined, addresses wrap.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready   request handshake; ready only while idle
//   req_we, req_funct3      store flag and RV32I width/sign code
//   req_addr, req_wdata     byte address and right-aligned store data
//   rsp_valid               one-cycle completion pulse
//   rsp_err, rsp_rdata      rejection flag and extended load data
//   ram_wen/ram_waddr/ram_wdata   RAM write port (word address)
//   ram_ren/ram_raddr/ram_rdata   RAM read port; data arrives one cycle after ren
module load_store_unit #(
  parameter  int MEM_DEPTH = 256,
  localparam int RAM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [RAM_AW-1:0] ram_raddr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_RMW  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          lane_q, lane_d;
  logic [RAM_AW-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                ram_wen_q, ram_wen_d;
  logic                ram_ren_q, ram_ren_d;

  logic                req_err;
  logic                range_err;
  logic [31:0]         rmw_word;
  logic [31:0]         load_word;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[31:RAM_AW+2];
`else
  // Upper address bits are deliberately ignored so accesses alias modulo the RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:RAM_AW+2];
  assign range_err      = 1'b0;
`endif

  // Rejection rules evaluated on the live request at acceptance.
  always_comb begin
    req_err = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
      req_err = 1'b1;
    if (req_we && req_funct3[2])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (range_err)
      req_err = 1'b1;
  end

  // Old word with the addressed byte or half replaced by the store data.
  always_comb begin
    rmw_word = ram_rdata;
    if (f3_q[0])
      rmw_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      rmw_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  // Lane extraction plus sign/zero extension for the returned load word.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = ram_rdata[{lane_q, 3'b000} +: 8];
    h = ram_rdata[{lane_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_word = {{24{b[7]}}, b};
      3'b100:  load_word = {24'd0, b};
      3'b001:  load_word = {{16{h[15]}}, h};
      3'b101:  load_word = {16'd0, h};
      default: load_word = ram_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          f3_d      = req_funct3;
          lane_d    = req_addr[1:0];
          word_d    = req_addr[RAM_AW+1:2];
          wdata_d   = req_wdata;
          rsp_err_d = req_err;
          if (req_err || req_we)
            rsp_rdata_d = 32'd0;
          if (req_err)
            state_d = S_RESP;
          else if (req_we && req_funct3 == 3'b010)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_WR:   state_d = S_RESP;
      S_RD:   state_d = we_q ? S_RMW : S_CAP;
      S_CAP: begin
        rsp_rdata_d = load_word;
        state_d     = S_RESP;
      end
      S_RMW:  state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered from the next state so they line up with it.
    ram_wen_d   = (state_d == S_WR) || (state_d == S_RMW);
    ram_ren_d   = (state_d == S_RD);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      word_q      <= '0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_wen_q   <= ram_wen_d;
      ram_ren_q   <= ram_ren_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_wen   = ram_wen_q;
  assign ram_ren   = ram_ren_q;
  assign ram_waddr = word_q;
  assign ram_raddr = word_q;
  // Read data for the merge only exists during RMW, so the merged word is not registered.
  assign ram_wdata = (state_q == S_RMW) ? rmw_word : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int MEM_DEPTH = 256;
  localparam int AW        = 8;
  localparam int NBYTES    = MEM_DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;
  logic          ram_wen;
  logic          ram_ren;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'd0;

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM attached to the DUT: registered read, no byte enables.
  logic [31:0] ram [0:MEM_DEPTH-1];
  always @(posedge clk) begin
    if (ram_wen) ram[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= ram[ram_raddr];
  end

  // Reference memory as plain bytes.
  logic [7:0] ref_mem [0:NBYTES-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    if ((f3 == 1 || f3 == 5) && addr[0]) return 1'b1;
    if (f3 == 2 && addr[1:0] != 2'b00) return 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if ((addr >> (AW + 2)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int nbytes_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned   ba;
    int            n;
    longint unsigned v;
    ba = addr % NBYTES;
    n  = nbytes_of(f3);
    v  = 0;
    for (int i = 0; i < n; i++)
      v += {56'd0, ref_mem[ba + i]} << (8 * i);
    if (!f3[2] && n < 4 && v[8 * n - 1])
      v += 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned ba;
    ba = addr % NBYTES;
    for (int i = 0; i < nbytes_of(f3); i++)
      ref_mem[ba + i] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] model_word(input int unsigned idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  // Issue one request and check every cycle until its response pulse.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit has_lit, input logic [31:0] lit);
    bit          e;
    bit          sw;
    int          lat;
    int unsigned widx;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    bit          exp_wen, exp_ren, exp_rv;
    e        = model_err(we, f3, addr);
    sw       = we && (f3 == 3'b010);
    widx     = (addr % NBYTES) / 4;
    exp_rd   = 32'd0;
    exp_word = 32'd0;
    if (!e && !we) exp_rd = model_load(f3, addr);
    if (!e && we) begin
      model_store(f3, addr, wd);
      exp_word = model_word(widx);
    end
    if (has_lit) chk("model_pin", exp_rd, lit);
    lat = e ? 1 : (sw ? 2 : 3);

    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      exp_wen = !e && ((sw && k == 1) || (we && !sw && k == 2));
      exp_ren = !e && !sw && k == 1;
      exp_rv  = (k == lat);
      chk("ram_wen", {31'd0, ram_wen}, {31'd0, exp_wen});
      chk("ram_ren", {31'd0, ram_ren}, {31'd0, exp_ren});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (exp_wen) begin
        chk("ram_waddr", {24'd0, ram_waddr}, widx);
        chk("ram_wdata", ram_wdata, exp_word);
      end
      if (exp_ren) chk("ram_raddr", {24'd0, ram_raddr}, widx);
      if (exp_rv) begin
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        if (has_lit) chk("rsp_rdata_lit", rsp_rdata, lit);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(w >> (8 * b));
    end

    // Reset values while held in reset.
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_ram_strobes", {30'd0, ram_wen, ram_ren}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence with literal expectations.
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'd0);
    do_req(0, 3'b010, 32'h10, 32'd0, 1, 32'hDEADBEEF);
    do_req(0, 3'b000, 32'h13, 32'd0, 1, 32'hFFFFFFDE);
    do_req(0, 3'b100, 32'h13, 32'd0, 1, 32'h000000DE);
    do_req(0, 3'b001, 32'h10, 32'd0, 1, 32'hFFFFBEEF);
    do_req(0, 3'b101, 32'h12, 32'd0, 1, 32'h0000DEAD);
    do_req(1, 3'b000, 32'h11, 32'h00000055, 0, 32'd0);
    do_req(0, 3'b010, 32'h10, 32'd0, 1, 32'hDEAD55EF);
    do_req(0, 3'b010, 32'h12, 32'd0, 1, 32'd0);
    do_req(1, 3'b001, 32'h01, 32'h1234, 1, 32'd0);
    do_req(0, 3'b011, 32'h10, 32'd0, 1, 32'd0);
    do_req(1, 3'b100, 32'h10, 32'd0, 1, 32'd0);
    do_req(1, 3'b010, 32'h400, 32'h12345678, 0, 32'd0);
`ifdef LSU_RANGE_CHECK_EN
    do_req(0, 3'b010, 32'h400, 32'd0, 1, 32'd0);
    do_req(0, 3'b010, 32'h000, 32'd0, 0, 32'd0);
`else
    do_req(0, 3'b010, 32'h000, 32'd0, 1, 32'h12345678);
`endif

    // Reset during the read phase of an SB abandons the write.
    do_req(1, 3'b010, 32'h20, 32'h11223344, 0, 32'd0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h21;
    req_wdata  = 32'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("sb_rd_ren", {31'd0, ram_ren}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {29'd0, rsp_valid, ram_wen, ram_ren}, 32'd0);
    chk("mid_rst_err_rdata", rsp_rdata | {31'd0, rsp_err}, 32'd0);
    chk("mid_rst_addr", {16'd0, ram_waddr, ram_raddr}, 32'd0);
    chk("mid_rst_wdata", ram_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_ram_word", ram[8], 32'h11223344);
    do_req(0, 3'b010, 32'h20, 32'd0, 1, 32'h11223344);

    // Randomized traffic against the byte model.
    for (int n = 0; n < 300; n++) begin
      logic [2:0] f3;
      bit         we;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << (AW + 2));
      do_req(we, f3, a, $urandom, 0, 32'd0);
    end

    @(negedge clk);
    for (int i = 0; i < MEM_DEPTH; i++) chk("ram_final", ram[i], model_word(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
